// File: rtl/register_load_arbiter_if.sv
// Handshake and data bundle between the requesters and the shared-register load arbiter.
interface register_load_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] data_in;
    logic               carga;
    logic [WIDTH-1:0]   load_data;
    logic [3:0]         gnt;
    logic [3:0]         ack;
    logic               busy;
    logic [WIDTH-1:0]   Q;

    modport master (
        output req,
        output data_in,
        input  carga,
        input  load_data,
        input  gnt,
        input  ack,
        input  busy,
        input  Q
    );

    modport slave (
        input  req,
        input  data_in,
        output carga,
        output load_data,
        output gnt,
        output ack,
        output busy,
        output Q
    );
endinterface

// File: rtl/register_load_arbiter.sv
// Round-robin arbiter granting one of four requesters a one-cycle load into a shared register.
module register_load_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset_async,
    register_load_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StAck} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] load_data_q, load_data_d;
    logic             carga_q, carga_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [3:0]       ack_q, ack_d;
    logic             busy_q;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       win_q, win_d;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       cand;

    // First set request bit searching upward from rr_ptr, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        load_data_d = load_data_q;
        carga_d     = carga_q;
        gnt_d       = gnt_q;
        ack_d       = ack_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d       = 4'b0001 << win_idx;
                    load_data_d = bus.data_in[int'(win_idx)*WIDTH +: WIDTH];
                    carga_d     = 1'b1;
                    win_d       = win_idx;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                q_d      = load_data_q;
                carga_d  = 1'b0;
                ack_d    = gnt_q;
                rr_ptr_d = win_q + 2'd1;
                state_d  = StAck;
            end
            StAck: begin
                ack_d   = 4'b0000;
                gnt_d   = 4'b0000;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            state_q     <= StIdle;
            q_q         <= '0;
            load_data_q <= '0;
            carga_q     <= 1'b0;
            gnt_q       <= 4'b0000;
            ack_q       <= 4'b0000;
            busy_q      <= 1'b0;
            rr_ptr_q    <= 2'd0;
            win_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            load_data_q <= load_data_d;
            carga_q     <= carga_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            busy_q      <= (state_d != StIdle);
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.load_data = load_data_q;
    assign bus.carga     = carga_q;
    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_register_load_arbiter.sv
// Directed bench for register_load_arbiter: reset, single load, contention, round-robin, reset mid-load.
module tb_register_load_arbiter;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic reset_async;
    int   vectors;
    int   errors;

    register_load_arbiter_if #(.WIDTH(WIDTH)) bus ();

    register_load_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_async (reset_async),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        reset_async = 1'b0;
        bus.req     = 4'b0000;
        bus.data_in = '0;

        // Reset and idle
        step();
        step();
        chk("rst_q", 32'(bus.Q), 32'h0);
        chk("rst_carga", 32'(bus.carga), 32'h0);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        reset_async = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_carga", 32'(bus.carga), 32'h0);
            chk("idle_q", 32'(bus.Q), 32'h0);
        end

        // Single load from requester 1
        bus.data_in = {8'h00, 8'h00, 8'hA5, 8'h00};
        bus.req     = 4'b0010;
        step();
        chk("single_carga", 32'(bus.carga), 32'h1);
        chk("single_gnt", 32'(bus.gnt), 32'h2);
        chk("single_ld", 32'(bus.load_data), 32'hA5);
        chk("single_busy", 32'(bus.busy), 32'h1);
        chk("single_q_hold", 32'(bus.Q), 32'h0);
        step();
        chk("single_q", 32'(bus.Q), 32'hA5);
        chk("single_ack", 32'(bus.ack), 32'h2);
        chk("single_carga0", 32'(bus.carga), 32'h0);
        bus.req = 4'b0000;
        step();
        chk("single_ack0", 32'(bus.ack), 32'h0);
        chk("single_gnt0", 32'(bus.gnt), 32'h0);
        chk("single_busy0", 32'(bus.busy), 32'h0);

        // Clear rr_ptr so contention starts at requester 0
        reset_async = 1'b0;
        step();
        reset_async = 1'b1;
        step();

        // Full contention
        bus.data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req     = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("cont_gnt", 32'(bus.gnt), 32'(4'b0001 << k));
            chk("cont_carga", 32'(bus.carga), 32'h1);
            chk("cont_ld", 32'(bus.load_data), 32'h10 + 32'(k));
            step();
            chk("cont_q", 32'(bus.Q), 32'h10 + 32'(k));
            chk("cont_ack", 32'(bus.ack), 32'(4'b0001 << k));
            chk("cont_carga0", 32'(bus.carga), 32'h0);
            step();
            bus.req[k] = 1'b0;
            chk("cont_idle_ack", 32'(bus.ack), 32'h0);
            chk("cont_idle_busy", 32'(bus.busy), 32'h0);
        end

        // Round-robin resume: serve requester 2, then 3 must beat 0
        bus.data_in = {8'h33, 8'h22, 8'h11, 8'h44};
        bus.req     = 4'b0100;
        step();
        chk("rr2_gnt", 32'(bus.gnt), 32'h4);
        step();
        chk("rr2_q", 32'(bus.Q), 32'h22);
        bus.req = 4'b1101;
        step();
        step();
        chk("rr3_gnt", 32'(bus.gnt), 32'h8);
        step();
        chk("rr3_q", 32'(bus.Q), 32'h33);
        chk("rr3_ack", 32'(bus.ack), 32'h8);
        bus.req = 4'b0101;
        step();
        bus.req = 4'b0001;
        step();
        chk("rr0_gnt", 32'(bus.gnt), 32'h1);
        step();
        chk("rr0_q", 32'(bus.Q), 32'h44);
        chk("rr0_ack", 32'(bus.ack), 32'h1);
        bus.req = 4'b0000;
        step();
        step();

        // Withdrawal during LOAD
        bus.data_in = {8'h00, 8'h00, 8'h00, 8'h5A};
        bus.req     = 4'b0001;
        step();
        chk("wd_gnt", 32'(bus.gnt), 32'h1);
        chk("wd_ld", 32'(bus.load_data), 32'h5A);
        bus.req     = 4'b0000;
        bus.data_in = {8'h00, 8'h00, 8'h00, 8'hFF};
        step();
        chk("wd_q", 32'(bus.Q), 32'h5A);
        chk("wd_ack", 32'(bus.ack), 32'h1);
        step();
        chk("wd_ack0", 32'(bus.ack), 32'h0);
        step();
        chk("wd_no_reack", 32'(bus.ack), 32'h0);
        chk("wd_q_hold", 32'(bus.Q), 32'h5A);
        chk("wd_carga0", 32'(bus.carga), 32'h0);

        // Reset mid-load
        bus.data_in = {8'h00, 8'h77, 8'h00, 8'h00};
        bus.req     = 4'b0100;
        step();
        chk("rml_carga", 32'(bus.carga), 32'h1);
        reset_async = 1'b0;
        bus.req     = 4'b0000;
        #1;
        chk("rml_q", 32'(bus.Q), 32'h0);
        chk("rml_carga0", 32'(bus.carga), 32'h0);
        chk("rml_gnt0", 32'(bus.gnt), 32'h0);
        chk("rml_busy0", 32'(bus.busy), 32'h0);
        step();
        reset_async = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rml_no_ack", 32'(bus.ack), 32'h0);
            chk("rml_q_hold", 32'(bus.Q), 32'h0);
        end
        bus.data_in = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        bus.req     = 4'b1111;
        step();
        chk("rml_gnt_r0", 32'(bus.gnt), 32'h1);
        step();
        chk("rml_q_r0", 32'(bus.Q), 32'hD0);
        bus.req = 4'b0000;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/register_load_arbiter.md
Name: register_load_arbiter

Overview:
- Round-robin load controller that shares one WIDTH-bit parallel-load register among 4 requesters.
- Selects one requester, drives the register's load enable (carga) and load data for exactly one cycle, then returns a one-cycle acknowledge.
- Contains the shared register internally and exposes its contents on Q.
- Sits between producer blocks and the register file built from the team's 1-bit parallel-load register cells.

Parameters:
WIDTH, 8, bit width of the shared register and of each requester's data word

Ports:
clk  input  1  rising-edge clock
reset_async  input  1  asynchronous active-low reset; 0 clears all state immediately
req  input  4  load request, one bit per requester; level, held until acknowledged
data_in  input  4*WIDTH  requester k data in bits [k*WIDTH +: WIDTH]
carga  output  1  register load enable, high exactly one cycle per granted load
load_data  output  WIDTH  data word being loaded, valid while carga=1
gnt  output  4  one-hot grant, high during LOAD and ACK of the owning requester
ack  output  4  one-hot, one-cycle pulse: the requester's data is now in Q
busy  output  1  1 whenever state != IDLE
Q  output  WIDTH  current shared register contents

Behaviour:
- Reset (reset_async=0, asynchronous): state=IDLE, Q=0, load_data=0, carga=0, gnt=0, ack=0, busy=0, rr_ptr=0. All outputs are registered.
- FSM states are IDLE, LOAD, ACK. Every state lasts one cycle except IDLE.
- IDLE: req is sampled only in this state.
  - If req==0: stay in IDLE, Q holds.
  - Otherwise pick winner w at the edge: the first set bit searching rr_ptr, rr_ptr+1, … modulo 4.
  - At that edge: gnt<=onehot(w), load_data<=data_in[w], carga<=1, state<=LOAD.
- LOAD, next edge: Q<=load_data, carga<=0, ack[w]<=1, rr_ptr<=(w+1) mod 4, state<=ACK.
- ACK, next edge: ack<=0, gnt<=0, state<=IDLE.
- Latency and throughput:
  - Request seen at IDLE edge E0 → carga high E0..E1 → Q updated and ack high at E1 → idle at E2.
  - Earliest next grant is at E3, giving a peak throughput of one load per 3 cycles.
- Q changes only on the LOAD→ACK edge. It holds its value in all other cycles.
- Data is captured at grant. Changes to data_in or req during LOAD/ACK do not affect the load in progress.
- Requester protocol: hold req and data until ack is seen, then deassert req before the next IDLE sampling edge. A req still high when IDLE is reached is treated as a new request.
- req dropped during LOAD: the load still completes and ack still pulses.
- At most one bit of gnt and of ack is set at any time. carga=1 implies exactly one gnt bit is set.
- Reset mid-operation (any state): immediate clear as above. No ack is issued after release, and a pending load is discarded.
- rr_ptr advances only on a completed load. With no requests it is unchanged.

Test Plan:
- Reset and idle: hold reset_async=0 → Q=0, carga=0, gnt=0, ack=0, busy=0. Release with req=0 for 10 cycles → Q stays 0 and carga is never 1.
- Single load: req=4'b0010, data1=8'hA5 → edge 1: carga=1, gnt=0010, load_data=A5. Edge 2: Q=A5, ack=0010, carga=0. Edge 3: ack=0, gnt=0, busy=0.
- Full contention: req=4'b1111 held, each requester deasserting req one cycle after its ack, data_k=8'h10+k → grants in order 0,1,2,3. Q sequence is 10,11,12,13, each with a 3-cycle spacing between carga pulses.
- Round-robin resume: after serving requester 2, req=4'b1101 → requester 3 is granted first, then requester 0. Q=data3, then data0.
- Withdrawal: req=0001 granted, req dropped and data0 changed during LOAD → Q equals the data captured at grant and ack[0] pulses once.
- Reset mid-load: pull reset_async low while in LOAD → Q=0 and carga=0 immediately. After release with req=0, no ack pulse occurs and rr_ptr=0, so req=1111 grants requester 0.
